// File: rtl/spi_seg7_mux.sv
// SPI slave (any CPOL/CPHA) that takes address/nibble frames into a DIGITS-wide hex display and scans it.
// Frame-to-rx_valid: 3 clk after the raw 8th sample edge; segments/an are registered and change together.
module spi_seg7_mux #(
   parameter int DIGITS         = 4,
   parameter int SPI_MODE       = 0,
   parameter int REFRESH_DIV    = 1000,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              e,
   output logic              f,
   output logic              g,
   output logic [DIGITS-1:0] an,
   output logic [7:0]        rx_data,
   output logic              rx_valid
);

   localparam logic CPOL = ((SPI_MODE >> 1) & 1) != 0;
   localparam logic CPHA = (SPI_MODE & 1) != 0;
   localparam logic INV  = SEG_ACTIVE_LOW != 0;
   localparam int   IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int   SW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [1:0] ss_sync, sck_sync, mosi_sync;
   logic       ss_prev, sck_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= 2'b11;
         sck_sync  <= {2{CPOL}};
         mosi_sync <= 2'b00;
         ss_prev   <= 1'b1;
         sck_prev  <= CPOL;
      end else begin
         ss_sync   <= {ss_sync[0], ss};
         sck_sync  <= {sck_sync[0], sck};
         mosi_sync <= {mosi_sync[0], mosi};
         ss_prev   <= ss_sync[1];
         sck_prev  <= sck_sync[1];
      end
   end

   logic       ss_fall, ss_rise, sck_lead, sck_trail, sample_edge, shift_edge;
   logic       in_frame, frame_done;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift, rx_byte, tx_shift;

   assign ss_fall     = ss_prev & ~ss_sync[1];
   assign ss_rise     = ~ss_prev & ss_sync[1];
   assign sck_lead    = (sck_sync[1] != sck_prev) && (sck_sync[1] != CPOL);
   assign sck_trail   = (sck_sync[1] != sck_prev) && (sck_sync[1] == CPOL);
   assign sample_edge = CPHA ? sck_trail : sck_lead;
   assign shift_edge  = CPHA ? sck_lead : sck_trail;
   // Using the delayed ss lets an 8th bit coincident with ss rise still complete.
   assign in_frame    = ~ss_prev;
   assign frame_done  = in_frame && sample_edge && (bit_cnt == 3'd7);
   assign rx_byte     = {rx_shift[6:0], mosi_sync[1]};
   assign miso        = tx_shift[7] & ~ss_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_shift <= 8'h00;
      end else begin
         rx_valid <= frame_done;
         if (in_frame && sample_edge) begin
            rx_shift <= rx_byte;
            bit_cnt  <= bit_cnt + 3'd1;
         end
         if (frame_done)
            rx_data <= rx_byte;
         if (ss_fall || ss_rise)
            bit_cnt <= 3'd0;
         // Bit 0 of each frame is already on miso, so the edge with bit_cnt==0 never shifts.
         if (ss_prev)
            tx_shift <= rx_data;
         else if (frame_done)
            tx_shift <= rx_byte;
         else if (shift_edge && bit_cnt != 3'd0)
            tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

   logic [3:0]        digit [DIGITS];
   logic [DIGITS-1:0] blank;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DIGITS; i++)
            digit[i] <= 4'h0;
         blank <= '1;
      end else if (frame_done) begin
         if (rx_byte[7:4] == 4'hF) begin
            blank <= '1;
         end else begin
            for (int i = 0; i < DIGITS; i++) begin
               if (rx_byte[7:4] == 4'(i)) begin
                  digit[i] <= rx_byte[3:0];
                  blank[i] <= 1'b0;
               end
            end
         end
      end
   end

   logic [SW-1:0] slot;
   logic [IW-1:0] idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
         idx  <= '0;
      end else if (slot == SW'(REFRESH_DIV - 1)) begin
         slot <= '0;
         idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         slot <= slot + 1'b1;
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1111110;
         4'h1: hex7 = 7'b0110000;
         4'h2: hex7 = 7'b1101101;
         4'h3: hex7 = 7'b1111001;
         4'h4: hex7 = 7'b0110011;
         4'h5: hex7 = 7'b1011011;
         4'h6: hex7 = 7'b1011111;
         4'h7: hex7 = 7'b1110000;
         4'h8: hex7 = 7'b1111111;
         4'h9: hex7 = 7'b1111011;
         4'hA: hex7 = 7'b1110111;
         4'hB: hex7 = 7'b0011111;
         4'hC: hex7 = 7'b1001110;
         4'hD: hex7 = 7'b0111101;
         4'hE: hex7 = 7'b1001111;
         default: hex7 = 7'b1000111;
      endcase
   endfunction

   logic [6:0]        seg_nxt, seg_q;
   logic [DIGITS-1:0] an_nxt;

   always_comb begin
      seg_nxt     = 7'b0000000;
      an_nxt      = '0;
      an_nxt[idx] = 1'b1;
      if (!blank[idx])
         seg_nxt = hex7(digit[idx]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q <= {7{INV}};
         an    <= {DIGITS{INV}};
      end else begin
         seg_q <= seg_nxt ^ {7{INV}};
         an    <= an_nxt ^ {DIGITS{INV}};
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_spi_seg7_mux.sv
// Four instances (one per SPI mode, mode 3 active-low); frame stimulus feeds a scoreboard checked by a monitor.
module tb_spi_seg7_mux;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int H  = 6;
   localparam logic [6:0] HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                       7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] ss_v, sck_v, mosi_v;
   logic [3:0] miso_v, rxv_w;
   logic [3:0][6:0] seg_w;
   logic [3:0][3:0] an_w;
   logic [3:0][7:0] rxd_w;

   always #5 clk = ~clk;

   genvar gm;
   generate
      for (gm = 0; gm < 4; gm++) begin : g_dut
         spi_seg7_mux #(
            .DIGITS(ND), .SPI_MODE(gm), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW((gm == 3) ? 1 : 0)
         ) u_dut (
            .clk(clk), .rst(rst), .ss(ss_v[gm]), .sck(sck_v[gm]), .mosi(mosi_v[gm]),
            .miso(miso_v[gm]),
            .a(seg_w[gm][6]), .b(seg_w[gm][5]), .c(seg_w[gm][4]), .d(seg_w[gm][3]),
            .e(seg_w[gm][2]), .f(seg_w[gm][1]), .g(seg_w[gm][0]),
            .an(an_w[gm]), .rx_data(rxd_w[gm]), .rx_valid(rxv_w[gm])
         );
      end
   endgenerate

   logic [7:0] exp_q [4][$];
   logic [7:0] echo_exp [$];
   logic [7:0] echo_got [$];
   logic [7:0] s_last [4];
   bit         done = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [3:0]    m_dig [4][ND];
   logic [ND-1:0] m_blank [4];
   logic [7:0]    m_last [4];
   int            prev_idx [4];
   int            run [4];

   task automatic check_inst(input int m);
      logic [6:0] seg, eseg;
      logic [3:0] an;
      logic [7:0] e;
      int idx;
      seg = seg_w[m] ^ {7{(m == 3)}};
      an  = an_w[m] ^ {4{(m == 3)}};
      if (rst) begin
         checks++;
         if (seg !== 7'h0 || an !== 4'h0 || rxd_w[m] !== 8'h00 || rxv_w[m] !== 1'b0 || miso_v[m] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst%0d: seg=%b an=%b rx_data=%h rx_valid=%b miso=%b, required all inactive and zero",
                     m, seg, an, rxd_w[m], rxv_w[m], miso_v[m]);
         end
         for (int dd = 0; dd < ND; dd++) m_dig[m][dd] = 4'h0;
         m_blank[m]  = '1;
         m_last[m]   = 8'h00;
         prev_idx[m] = -1;
         run[m]      = 0;
         return;
      end
      checks++;
      if (!$onehot(an)) begin
         errors++;
         $display("FAIL scan_onehot inst%0d: an=%b, required one active digit", m, an);
         prev_idx[m] = -1;
      end else begin
         idx = 0;
         for (int dd = 0; dd < ND; dd++) if (an[dd]) idx = dd;
         eseg = m_blank[m][idx] ? 7'h00 : HEX[m_dig[m][idx]];
         checks++;
         if (seg !== eseg) begin
            errors++;
            $display("FAIL segments inst%0d digit%0d: got %b, required %b", m, idx, seg, eseg);
         end
         if (idx != prev_idx[m]) begin
            checks++;
            if (prev_idx[m] < 0) begin
               if (idx != 0) begin
                  errors++;
                  $display("FAIL scan_start inst%0d: first digit %0d, required 0", m, idx);
               end
            end else if (idx != (prev_idx[m] + 1) % ND || run[m] != RD) begin
               errors++;
               $display("FAIL scan_step inst%0d: %0d->%0d after %0d clk, required %0d->%0d after %0d clk",
                        m, prev_idx[m], idx, run[m], prev_idx[m], (prev_idx[m] + 1) % ND, RD);
            end
            prev_idx[m] = idx;
            run[m] = 1;
         end else begin
            run[m]++;
         end
      end
      checks++;
      if (rxv_w[m]) begin
         if (exp_q[m].size() == 0) begin
            errors++;
            $display("FAIL rx_valid_unexpected inst%0d: rx_data=%h, required no pulse", m, rxd_w[m]);
         end else begin
            e = exp_q[m].pop_front();
            if (rxd_w[m] !== e) begin
               errors++;
               $display("FAIL rx_data inst%0d: got %h, required %h", m, rxd_w[m], e);
            end
            if (int'(e[7:4]) < ND) begin
               m_dig[m][int'(e[7:4])]   = e[3:0];
               m_blank[m][int'(e[7:4])] = 1'b0;
            end else if (e[7:4] == 4'hF) begin
               m_blank[m] = '1;
            end
            m_last[m] = e;
         end
      end else if (rxd_w[m] !== m_last[m]) begin
         errors++;
         $display("FAIL rx_data_hold inst%0d: got %h, required %h", m, rxd_w[m], m_last[m]);
      end
   endtask

   always @(posedge clk) begin
      logic [7:0] ee, gg;
      #1;
      for (int m = 0; m < 4; m++) check_inst(m);
      while (echo_exp.size() > 0 && echo_got.size() > 0) begin
         ee = echo_exp.pop_front();
         gg = echo_got.pop_front();
         checks++;
         if (gg !== ee) begin
            errors++;
            $display("FAIL miso_echo: got %h, required %h", gg, ee);
         end
      end
      if (done) begin
         for (int m = 0; m < 4; m++) begin
            checks++;
            if (exp_q[m].size() != 0) begin
               errors++;
               $display("FAIL missing_rx_valid inst%0d: %0d frames outstanding, required 0", m, exp_q[m].size());
            end
         end
         checks++;
         if (echo_exp.size() != echo_got.size()) begin
            errors++;
            $display("FAIL echo_count: %0d captured vs %0d expected bytes", echo_got.size(), echo_exp.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input int m, input logic [15:0] data, input int nbits);
      logic cpol, cpha, bt;
      logic [7:0] got, byt, prev;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      prev = s_last[m];
      got  = 8'h00;
      for (int k = 0; k < nbits / 8; k++) begin
         byt = data[nbits - 1 - 8 * k -: 8];
         exp_q[m].push_back(byt);
         echo_exp.push_back(prev);
         prev = byt;
      end
      s_last[m] = prev;
      ss_v[m] = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         bt = data[nbits - 1 - i];
         if (!cpha) mosi_v[m] = bt;
         clks(H);
         if (!cpha) got = {got[6:0], miso_v[m]};
         sck_v[m] = ~cpol;
         if (cpha) mosi_v[m] = bt;
         clks(H);
         if (cpha) got = {got[6:0], miso_v[m]};
         sck_v[m] = cpol;
         if (i % 8 == 7) echo_got.push_back(got);
      end
      clks(H);
      ss_v[m] = 1'b1;
      clks(2 * H);
   endtask

   function automatic logic [7:0] rand_frame();
      int r;
      logic [3:0] addr;
      r = $urandom_range(0, 9);
      if (r < 6)      addr = 4'($urandom_range(0, ND - 1));
      else if (r < 8) addr = 4'hF;
      else            addr = 4'($urandom_range(ND, 14));
      return {addr, 4'($urandom)};
   endfunction

   initial begin
      int m, r;
      ss_v   = 4'b1111;
      sck_v  = 4'b1100;
      mosi_v = 4'b0000;
      for (int i = 0; i < 4; i++) s_last[i] = 8'h00;
      clks(4);
      rst = 1'b0;
      clks(2 * RD * ND);
      xfer(0, 16'h0001, 8);  clks(2 * RD * ND);
      xfer(0, 16'h0028, 8);
      xfer(0, 16'h003A, 8);  clks(2 * RD * ND);
      xfer(0, 16'h0055, 8);  clks(RD * ND);
      xfer(0, 16'h00F0, 8);  clks(RD * ND);
      xfer(0, 16'h0007, 8);
      xfer(0, 16'h0000, 5);  clks(RD * ND);
      for (int i = 0; i < 4; i++) begin
         xfer(i, 16'h00A5, 8);
         xfer(i, 16'h0000, 8);
      end
      xfer(3, 16'h0008, 8);  clks(2 * RD * ND);
      xfer(0, 16'h1C2D, 16); clks(RD * ND);
      // Reset in the middle of a mode-3 frame
      ss_v[3] = 1'b0;
      mosi_v[3] = 1'b1;
      clks(H); sck_v[3] = 1'b0;
      clks(H); sck_v[3] = 1'b1;
      clks(H);
      rst = 1'b1;
      clks(3);
      ss_v[3] = 1'b1;
      clks(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) s_last[i] = 8'h00;
      clks(RD * ND);
      for (int it = 0; it < 48; it++) begin
         m = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         if (r < 6)      xfer(m, {8'h00, rand_frame()}, 8);
         else if (r < 9) xfer(m, {rand_frame(), rand_frame()}, 16);
         else            xfer(m, 16'($urandom), $urandom_range(1, 7));
         clks($urandom_range(0, 2 * RD * ND));
      end
      clks(2 * RD * ND);
      done = 1'b1;
   end

endmodule
